fetch_queue: RTL and testbench

//  Instruction-byte prefetch stage between MEMORY and the cpu decode/state machine.
//  - Reads sequential bytes from memory starting at a program address.
//  - Buffers them in a small FIFO and presents the head byte plus its address to the cpu.
//  - Discards buffered and in-flight bytes on flush (jmp/branch/reset).

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue_byte_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: fetch FSM state encodings
// and a width helper used by both the queue and its byte store.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fq_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_byte_fifo.sv
// DEPTH x 8 circular byte store with single/double pop and flush; exposes the
// head and the entry behind it so a consumer can peek an opcode+operand pair.
module byte_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [7:0]                push_data,
  input  logic                      pop,
  input  logic                      pop2,
  input  logic                      flush,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [7:0]                head,
  output logic                      head_vld,
  output logic [7:0]                second,
  output logic                      second_vld
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d, rd_nx;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            pop_n;

  always_comb begin
    pop_n = pop2 ? 2'd2 : {1'b0, pop};
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q + PTR_W'(pop_n);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop_n);
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_nx      = rd_q + PTR_W'(1);
  assign count      = cnt_q;
  assign head       = mem_q[rd_q];
  assign head_vld   = (cnt_q != '0);
  assign second     = mem_q[rd_nx];
  assign second_vld = (cnt_q >= CNT_W'(2));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-byte prefetch between memory and decode. Optional two-byte peek/pop
// is enabled by defining FETCH_QUEUE_PEEK2_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                  CLK,
  input  logic                  R,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  input  logic [7:0]            mem_data,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     flush_addr,
  input  logic                  take,
  output logic [7:0]            out_byte,
  output logic [ADDR_W-1:0]     out_pc,
  output logic                  out_valid,
`ifdef FETCH_QUEUE_PEEK2_EN
  output logic [7:0]            out_byte1,
  output logic                  out_valid1,
  input  logic                  take2,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = cnt_w(DEPTH);

  fq_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, out_pc_q, out_pc_d;
  logic              resp_vld_q, resp_vld_d, resp_stale_q, resp_stale_d;
  logic              accept, push, pop1, pop2, take2_i;
  logic [1:0]        pop_n;
  logic [CNT_W-1:0]  cnt;
  logic              head_vld, second_vld;
  logic [7:0]        second;

`ifdef FETCH_QUEUE_PEEK2_EN
  assign take2_i    = take2;
  assign out_byte1  = second;
  assign out_valid1 = second_vld;
`else
  logic unused_peek;
  assign take2_i     = 1'b0;
  assign unused_peek = ^{second, second_vld};
`endif

  // The in-flight response counts against capacity so a landing byte never overflows.
  assign mem_req = (state_q == ST_RUN) &&
                   (({1'b0, cnt} + (CNT_W+1)'(resp_vld_q)) < (CNT_W+1)'(DEPTH));

  always_comb begin
    accept       = mem_req && mem_gnt;
    push         = resp_vld_q && !resp_stale_q && !flush;
    pop2         = !flush && take2_i && second_vld;
    pop1         = !flush && !pop2 && take && head_vld;
    pop_n        = pop2 ? 2'd2 : {1'b0, pop1};
    resp_vld_d   = accept;
    resp_stale_d = flush;   // a request accepted under flush returns for the old stream
    fetch_addr_d = accept ? fetch_addr_q + ADDR_W'(1) : fetch_addr_q;
    out_pc_d     = out_pc_q + ADDR_W'(pop_n);
    state_d      = ST_RUN;
    if (flush) begin
      fetch_addr_d = flush_addr;
      out_pc_d     = flush_addr;
      state_d      = ST_FLUSH;
    end
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= RESET_ADDR;
      out_pc_q     <= RESET_ADDR;
      resp_vld_q   <= 1'b0;
      resp_stale_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      out_pc_q     <= out_pc_d;
      resp_vld_q   <= resp_vld_d;
      resp_stale_q <= resp_stale_d;
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .rst        (R),
    .push       (push),
    .push_data  (mem_data),
    .pop        (pop1),
    .pop2       (pop2),
    .flush      (flush),
    .count      (cnt),
    .head       (out_byte),
    .head_vld   (head_vld),
    .second     (second),
    .second_vld (second_vld)
  );

  assign mem_addr  = fetch_addr_q;
  assign out_pc    = out_pc_q;
  assign out_valid = head_vld;
  assign count     = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory responder plus an expected-byte
// scoreboard loaded on every program-address change and drained on each take.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        R;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_gnt;
  logic [7:0]  mem_data;
  logic        flush;
  logic [15:0] flush_addr;
  logic        take;
  logic [7:0]  out_byte;
  logic [15:0] out_pc;
  logic        out_valid;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_PEEK2_EN
  logic [7:0]  out_byte1;
  logic        out_valid1;
  logic        take2;
`endif

  fetch_queue #(.DEPTH(4), .ADDR_W(16), .RESET_ADDR(16'h0000)) dut (
    .CLK        (CLK),
    .R          (R),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_data   (mem_data),
    .flush      (flush),
    .flush_addr (flush_addr),
    .take       (take),
    .out_byte   (out_byte),
    .out_pc     (out_pc),
    .out_valid  (out_valid),
`ifdef FETCH_QUEUE_PEEK2_EN
    .out_byte1  (out_byte1),
    .out_valid1 (out_valid1),
    .take2      (take2),
`endif
    .count      (count)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:65535];

  // Memory answers an accepted request with data in the following cycle.
  always @(posedge CLK) mem_data <= (mem_req && mem_gnt) ? mem[mem_addr] : 8'hEE;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [15:0] a, input int n);
    logic [15:0] p;
    sb.delete();
    p = a;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: p, b: mem[p]});
      p = p + 16'd1;
    end
  endtask

  task automatic consume_one();
    exp_t e;
    if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
    else begin
      e = sb.pop_front();
      chk("pc", 32'(out_pc), 32'(e.pc));
      chk("byte", 32'(out_byte), 32'(e.b));
      n_pop++;
    end
  endtask

  // Called just after a negedge: drive take, score the pop it causes, advance one cycle.
  task automatic cyc(input logic tk);
    take = tk;
    if (tk && out_valid) consume_one();
    @(negedge CLK);
  endtask

  task automatic take_n(input int n, input int budget);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (out_valid) got++;
      cyc(1'b1);
    end
    take = 1'b0;
    chk("take_n_budget", 32'(got), 32'(n));
  endtask

  task automatic do_flush(input logic [15:0] a, input int n_exp);
    flush      = 1'b1;
    flush_addr = a;
    take       = 1'b1;           // must be overridden by flush
    @(negedge CLK);
    flush = 1'b0;
    take  = 1'b0;
    sb_load(a, n_exp);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_pc", 32'(out_pc), 32'(a));
    chk("fl_addr", 32'(mem_addr), 32'(a));
    chk("fl_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    logic saw_empty;
    int   waited;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    mem[0] = 8'hA9; mem[1] = 8'h05; mem[2] = 8'h85; mem[3] = 8'h10;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;

    R = 1'b1; mem_gnt = 1'b1; flush = 1'b0; flush_addr = '0; take = 1'b0;
`ifdef FETCH_QUEUE_PEEK2_EN
    take2 = 1'b0;
`endif
    // 1: reset values, first-byte latency, fill to capacity
    repeat (2) @(negedge CLK);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'h0000);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_byte", 32'(out_byte), 32'h00);
    chk("rst_pc", 32'(out_pc), 32'h0000);
    chk("rst_count", 32'(count), 32'd0);
    R = 1'b0;
    sb_load(16'h0000, 32);
    @(negedge CLK);                       // IDLE -> RUN
    chk("c1_req", 32'(mem_req), 32'd1);
    chk("c1_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    chk("c2_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    chk("c3_valid", 32'(out_valid), 32'd1);
    chk("c3_byte", 32'(out_byte), 32'hA9);
    chk("c3_pc", 32'(out_pc), 32'h0000);
    repeat (4) @(negedge CLK);
    chk("full_count", 32'(count), 32'd4);
    chk("full_req", 32'(mem_req), 32'd0);
    chk("full_addr", 32'(mem_addr), 32'h0004);

    // 2: take every cycle from full: in order, no gaps, count settles
    for (int i = 0; i < 10; i++) begin
      chk("stream_valid", 32'(out_valid), 32'd1);
      cyc(1'b1);
    end
    chk("steady_count", 32'(count), 32'd2);

    // 3: flush while a fetch is in flight; stale byte must not appear
    take = 1'b0;
    do_flush(16'h0200, 16);
    take_n(6, 40);

    // 4: address wrap at the top of memory
    do_flush(16'hFFFE, 16);
    take_n(5, 40);

    // 5: grant withheld mid-stream -> drain, then resume with next byte
    saw_empty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_gnt = (i >= 3);
      if (!out_valid) saw_empty = 1'b1;
      cyc(1'b1);
    end
    if (!out_valid) saw_empty = 1'b1;
    mem_gnt = 1'b1;
    chk("drain_empty", 32'(saw_empty), 32'd1);
    take_n(4, 40);

    // 6: asynchronous reset with three bytes queued, then restart
    take = 1'b0;
    waited = 0;
    while (count != 3'd3 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    chk("reach_cnt3", 32'(count), 32'd3);
    R = 1'b1;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_req", 32'(mem_req), 32'd0);
    chk("ar_addr", 32'(mem_addr), 32'h0000);
    chk("ar_pc", 32'(out_pc), 32'h0000);
    chk("ar_byte", 32'(out_byte), 32'h00);
    @(negedge CLK);
    R = 1'b0;
    sb_load(16'h0000, 16);
    take_n(4, 40);

`ifdef FETCH_QUEUE_PEEK2_EN
    // take2 pops an opcode+operand pair in one cycle
    waited = 0;
    while (count != 3'd4 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    chk("p2_full", 32'(count), 32'd4);
    mem_gnt = 1'b0;
    chk("p2_valid1", 32'(out_valid1), 32'd1);
    chk("p2_byte1", 32'(out_byte1), 32'(sb[1].b));
    take2 = 1'b1;
    take  = 1'b1;
    consume_one();
    void'(sb.pop_front());
    @(negedge CLK);
    take2 = 1'b0;
    take  = 1'b0;
    chk("p2_count", 32'(count), 32'd2);
    chk("p2_pc", 32'(out_pc), 32'(sb[0].pc));
    mem_gnt = 1'b1;
`endif

    chk("pops_seen", 32'(n_pop > 20), 32'd1);
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
